mem_responder: RTL and testbench

Memory-side responder for the single-request-per-cycle mem_req/mem_write bus driven by the team's datapath engines (matmul and successors). Services every request cycle: writes commit into local storage; reads return data on mem_rdata_vld/mem_rdata after a fixed pipeline latency. Serves as the on-chip scratchpad behind an engine and as the bench's reference memory.

---
 rtl/mem_resp_pkg.sv | 30 +++
 rtl/mem_responder_if.sv | 41 ++++
 rtl/mem_resp_ram.sv | 37 +++
 rtl/mem_responder.sv | 173 +++++++++++++++++
 tb/tb_mem_responder.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and default sizing for the mem_responder slice.
// Imported by the responder top and its RAM sub-module.
package mem_resp_pkg;

    // Default bus and storage sizing
    localparam int MEM_AW_DEF   = 16;
    localparam int MEM_DW_DEF   = 32;
    localparam int DEPTH_AW_DEF = 10;
    localparam int RD_LAT_DEF   = 2;

    // Deepest read pipeline the responder is built for
    localparam int RD_LAT_MAX   = 4;

    // Responder control state: zero-fill first, then serve the bus
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } mem_resp_state_e;

    // Keeps a requested read latency inside the buildable range 1..RD_LAT_MAX
    function automatic int clamp_rd_lat(input int lat);
        if (lat < 1)
            return 1;
        else if (lat > RD_LAT_MAX)
            return RD_LAT_MAX;
        else
            return lat;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: single-request-per-cycle memory bus between a datapath
// engine (master) and the memory responder (slave).
//
// Handshake: there is no ready signal. Every cycle with mem_req=1 is one
// transaction, consumed at that rising edge; mem_write selects write (1) or
// read (0) and is only meaningful while mem_req=1. Each read returns exactly
// one mem_rdata_vld pulse a fixed number of cycles later, in request order;
// mem_rdata holds its last value between pulses. Writes produce no response.
interface mem_responder_if #(
    parameter int MEM_AW = mem_resp_pkg::MEM_AW_DEF,
    parameter int MEM_DW = mem_resp_pkg::MEM_DW_DEF
);

    logic              mem_req;
    logic              mem_write;
    logic [MEM_AW-1:0] mem_addr;
    logic [MEM_DW-1:0] mem_wdata;
    logic              mem_rdata_vld;
    logic [MEM_DW-1:0] mem_rdata;

    // Engine side: issues requests, receives read data
    modport master (
        output mem_req,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata_vld,
        input  mem_rdata
    );

    // Memory side: accepts requests, returns read data
    modport slave (
        input  mem_req,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata_vld,
        output mem_rdata
    );

endinterface

// File: rtl/mem_resp_ram.sv
// mem_resp_ram: 1-write/1-read synchronous word array with a registered,
// read-enabled output. A same-address write and read in one cycle returns
// the new data (write-first). The output register only moves on a read, so
// it holds the last read word between reads.
module mem_resp_ram
    import mem_resp_pkg::*;
#(
    parameter int AW = DEPTH_AW_DEF,
    parameter int DW = MEM_DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Storage write port; contents are not reset (the owner zero-fills)
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Registered read port with write-first bypass on an address collision
    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the mem_req/mem_write bus.
// After reset it zero-fills its 2^DEPTH_AW words (INIT), then serves one
// request per cycle (RUN): writes commit at the request edge, reads return
// after RD_LAT cycles on mem_rdata_vld/mem_rdata. Out-of-range or INIT-time
// requests raise the sticky err flag.
// Optional build macro MEM_RESP_STATS_EN adds saturating wr_cnt/rd_cnt outputs.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int MEM_AW   = MEM_AW_DEF,
    parameter int MEM_DW   = MEM_DW_DEF,
    parameter int DEPTH_AW = DEPTH_AW_DEF,
    parameter int RD_LAT   = RD_LAT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus,
    output logic            init_done,
    output logic            err,
    output mem_resp_state_e state_dbg
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [31:0]     wr_cnt,
    output logic [31:0]     rd_cnt
`endif
);

    // Effective pipeline depth; the RAM output register is the first stage
    localparam int LAT = clamp_rd_lat(RD_LAT);

    mem_resp_state_e     state;
    logic [DEPTH_AW-1:0] init_cnt;

    logic                oor;
    logic                acc;
    logic                acc_wr;
    logic                rd_en;
    logic                init_we;
    logic                ram_we;
    logic [DEPTH_AW-1:0] ram_waddr;
    logic [MEM_DW-1:0]   ram_wdata;
    logic [MEM_DW-1:0]   ram_q;

    logic                rd_zero;
    logic [MEM_DW-1:0]   stage0_data;
    logic [LAT-1:0]      vld_pipe;

    assign state_dbg = state;

    // An address is out of range when any bit above the implemented depth is set
    generate
        if (DEPTH_AW < MEM_AW) begin : g_range
            assign oor = |bus.mem_addr[MEM_AW-1:DEPTH_AW];
        end else begin : g_full
            assign oor = 1'b0;
        end
    endgenerate

    // Request decode and RAM write-port steering (zero-fill owns the port in INIT)
    always_comb begin
        acc       = (state == ST_RUN) && bus.mem_req;
        acc_wr    = acc && bus.mem_write;
        rd_en     = acc && !bus.mem_write;
        init_we   = (state == ST_INIT);
        ram_we    = init_we || (acc_wr && !oor);
        ram_waddr = init_we ? init_cnt : bus.mem_addr[DEPTH_AW-1:0];
        ram_wdata = init_we ? '0 : bus.mem_wdata;
    end

    mem_resp_ram #(
        .AW (DEPTH_AW),
        .DW (MEM_DW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (rd_en),
        .raddr (bus.mem_addr[DEPTH_AW-1:0]),
        .rdata (ram_q)
    );

    // Control FSM: walk the zero-fill counter, then run; track sticky err
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    // Requests here are dropped; only the error is recorded
                    if (bus.mem_req)
                        err <= 1'b1;
                    if (&init_cnt) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.mem_req && oor)
                        err <= 1'b1;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    // Read tag pipeline; the zero flag rides with the RAM output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            rd_zero  <= 1'b0;
        end else begin
            vld_pipe[0] <= rd_en;
            for (int i = 1; i < LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];
            if (rd_en)
                rd_zero <= oor;
        end
    end

    // Out-of-range reads still answer, but with zero data
    assign stage0_data = rd_zero ? '0 : ram_q;

    generate
        if (LAT == 1) begin : g_lat1
            assign bus.mem_rdata = stage0_data;
        end else begin : g_latn
            logic [MEM_DW-1:0] data_pipe [LAT-1];

            // Extra data stages advance only with a valid tag, so the last one holds
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LAT - 1; i++)
                        data_pipe[i] <= '0;
                end else begin
                    if (vld_pipe[0])
                        data_pipe[0] <= stage0_data;
                    for (int i = 1; i < LAT - 1; i++)
                        if (vld_pipe[i])
                            data_pipe[i] <= data_pipe[i-1];
                end
            end

            assign bus.mem_rdata = data_pipe[LAT-2];
        end
    endgenerate

    assign bus.mem_rdata_vld = vld_pipe[LAT-1];

`ifdef MEM_RESP_STATS_EN
    // Saturating counts of accepted RUN writes and reads, out-of-range included
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (acc_wr && (wr_cnt != '1))
                wr_cnt <= wr_cnt + 32'd1;
            if (rd_en && (rd_cnt != '1))
                rd_cnt <= rd_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder (DEPTH_AW=4, RD_LAT=2).
// A memory/queue model predicts read pulses, held data, init_done, err and
// state on every cycle; directed tasks add literal expectations.
// Build with MEM_RESP_STATS_EN defined to also cover wr_cnt/rd_cnt.
module tb_mem_responder;
    import mem_resp_pkg::*;

    localparam int AW       = 16;
    localparam int DW       = 32;
    localparam int DEPTH_AW = 4;
    localparam int DEPTH    = 1 << DEPTH_AW;
    localparam int RD_LAT   = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if #(.MEM_AW(AW), .MEM_DW(DW)) bus ();

    logic            init_done;
    logic            err;
    mem_resp_state_e state_dbg;
`ifdef MEM_RESP_STATS_EN
    logic [31:0]     wr_cnt;
    logic [31:0]     rd_cnt;
`endif

    mem_responder #(
        .MEM_AW   (AW),
        .MEM_DW   (DW),
        .DEPTH_AW (DEPTH_AW),
        .RD_LAT   (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .init_done (init_done),
        .err       (err),
        .state_dbg (state_dbg)
`ifdef MEM_RESP_STATS_EN
        ,
        .wr_cnt    (wr_cnt),
        .rd_cnt    (rd_cnt)
`endif
    );

    // ---------------- scoreboard state ----------------
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc   = 0;
    logic [DW-1:0] exp_q[$];
    int            due_q[$];
    logic [DW-1:0] got_q[$];
    int            got_cyc[$];
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] last_d = '0;
    logic          err_m  = 1'b0;
    logic          init_m = 1'b0;
    int            init_edges = 0;
    logic          req_oor;
    logic          exp_v;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: applies each bus request at the edge that samples it
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            due_q.delete();
            last_d     = '0;
            err_m      = 1'b0;
            init_m     = 1'b0;
            init_edges = 0;
            foreach (mem_m[i]) mem_m[i] = '0;
        end else begin
            req_oor = (bus.mem_addr >> DEPTH_AW) != 0;
            if (bus.mem_req && (!init_m || req_oor))
                err_m = 1'b1;
            if (bus.mem_req && init_m) begin
                if (bus.mem_write) begin
                    if (!req_oor)
                        mem_m[int'(bus.mem_addr) % DEPTH] = bus.mem_wdata;
                end else begin
                    exp_q.push_back(req_oor ? '0 : mem_m[int'(bus.mem_addr) % DEPTH]);
                    due_q.push_back(cyc + RD_LAT - 1);
                end
            end
            if (!init_m) begin
                init_edges++;
                if (init_edges == DEPTH)
                    init_m = 1'b1;
            end
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (cyc > 0) begin
            exp_v = 1'b0;
            if (due_q.size() > 0)
                exp_v = (due_q[0] == cyc);
            check("vld", {31'd0, bus.mem_rdata_vld}, {31'd0, exp_v});
            if (exp_v) begin
                last_d = exp_q.pop_front();
                void'(due_q.pop_front());
            end
            check("rdata", bus.mem_rdata, last_d);
            check("init_done", {31'd0, init_done}, {31'd0, init_m});
            check("err", {31'd0, err}, {31'd0, err_m});
            check("state", 32'(state_dbg), init_m ? 32'(ST_RUN) : 32'(ST_INIT));
            if (bus.mem_rdata_vld) begin
                got_q.push_back(bus.mem_rdata);
                got_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic bus_cycle(input logic req, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data);
        @(posedge clk);
        #1;
        bus.mem_req   = req;
        bus.mem_write = we;
        bus.mem_addr  = addr;
        bus.mem_wdata = data;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            bus_cycle(1'b0, 1'b0, '0, '0);
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.mem_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_init(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (init_done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic read_check(input string name, input logic [AW-1:0] addr,
                              input logic [DW-1:0] exp);
        int lat;
        lat = 0;
        bus_cycle(1'b1, 1'b0, addr, '0);
        bus_cycle(1'b0, 1'b0, '0, '0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.mem_rdata_vld) begin
                lat = i;
                break;
            end
        end
        check({name, "_lat"}, 32'(lat), 32'(RD_LAT));
        check({name, "_data"}, bus.mem_rdata, exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        bus.mem_req   = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        // Reset and zero-fill timing
        assert_reset();
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", bus.mem_rdata, 32'd0);
        wait_init(lat);
        check("init_lat", 32'(lat), 32'd16);
        read_check("rd5_zero", 16'h0005, 32'h0000_0000);

        // Write then read next cycle
        bus_cycle(1'b1, 1'b1, 16'h0003, 32'hDEAD_BEEF);
        read_check("rd3_new", 16'h0003, 32'hDEAD_BEEF);

        // Preload and four back-to-back reads
        for (int i = 0; i < 4; i++)
            bus_cycle(1'b1, 1'b1, 16'(i), 32'h10 + 32'(i));
        got_q.delete();
        got_cyc.delete();
        for (int i = 0; i < 4; i++)
            bus_cycle(1'b1, 1'b0, 16'(i), '0);
        idle(6);
        check("b2b_count", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("b2b_data", got_q[i], 32'h10 + 32'(i));
                check("b2b_cycle", 32'(got_cyc[i] - got_cyc[0]), 32'(i));
            end
        end

        // Boundary word and out-of-range accesses
        bus_cycle(1'b1, 1'b1, 16'h000F, 32'hA5A5_0F0F);
        read_check("rd_top", 16'h000F, 32'hA5A5_0F0F);
        check("err_before_oor", {31'd0, err}, 32'd0);
        read_check("rd_oor_16", 16'h0010, 32'h0000_0000);
        check("err_oor", {31'd0, err}, 32'd1);
        read_check("rd_oor_8000", 16'h8000, 32'h0000_0000);
        bus_cycle(1'b1, 1'b1, 16'h8000, 32'hCAFE_F00D);
        read_check("rd0_kept", 16'h0000, 32'h0000_0010);
        idle(3);
        check("err_sticky", {31'd0, err}, 32'd1);

        // Request during INIT is dropped and flags err
        assert_reset();
        check("rst2_err", {31'd0, err}, 32'd0);
        got_q.delete();
        bus_cycle(1'b1, 1'b0, 16'h0005, '0);
        bus_cycle(1'b0, 1'b0, '0, '0);
        idle(3);
        check("init_req_err", {31'd0, err}, 32'd1);
        check("init_req_novld", 32'(got_q.size()), 32'd0);
        wait_init(lat);
        check("init2_done", {31'd0, init_done}, 32'd1);

        // Reset with reads in flight: later pulses discarded, array re-zeroed
        bus_cycle(1'b1, 1'b1, 16'h0003, 32'h1234_5678);
        bus_cycle(1'b1, 1'b0, 16'h0003, '0);
        bus_cycle(1'b1, 1'b0, 16'h0000, '0);
        got_q.delete();
        assert_reset();
        check("rst3_init_done", {31'd0, init_done}, 32'd0);
        wait_init(lat);
        check("init3_lat", 32'(lat), 32'd16);
        check("flight_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1)
            check("flight_data", got_q[0], 32'h1234_5678);
        read_check("rd3_rezero", 16'h0003, 32'h0000_0000);

`ifdef MEM_RESP_STATS_EN
        // Statistics counters
        assert_reset();
        wait_init(lat);
        check("stats_rst_wr", wr_cnt, 32'd0);
        check("stats_rst_rd", rd_cnt, 32'd0);
        bus_cycle(1'b1, 1'b1, 16'h0001, 32'h1);
        bus_cycle(1'b1, 1'b1, 16'h0002, 32'h2);
        bus_cycle(1'b1, 1'b1, 16'h8000, 32'h3);
        for (int i = 0; i < 5; i++)
            bus_cycle(1'b1, 1'b0, 16'(i), '0);
        idle(4);
        check("stats_wr", wr_cnt, 32'd3);
        check("stats_rd", rd_cnt, 32'd5);
`endif

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
